// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low key matrix scanner with whole-map debounce and valid/ack key reporting.
// Build macro KEYPAD_FIFO_EN adds a 4-entry report FIFO and the KeyOverflow_o output.
module keypad_scanner #(
  parameter int CLOCK_HZ     = 10_000_000,
  parameter int SCAN_US      = 1000,
  parameter int STABLE_SCANS = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Rows_i,
  output logic [3:0] Columns_o,
  output logic [3:0] KeyCode_o,
  output logic       KeyValid_o,
  input  logic       KeyAck_i,
`ifdef KEYPAD_FIFO_EN
  output logic       KeyOverflow_o,
`endif
  output logic       KeyPressed_o
);

  localparam int DELAY = (CLOCK_HZ / 1_000_000) * SCAN_US - 1;
  localparam int CNT_W = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam int STB_W = $clog2(STABLE_SCANS);
  localparam logic [CNT_W-1:0] DELAY_C    = CNT_W'(DELAY);
  localparam logic [STB_W-1:0] STABLE_MAX = STB_W'(STABLE_SCANS - 1);

  typedef enum logic {
    SETTLE = 1'b0,
    EVAL   = 1'b1
  } state_t;

  // Lowest set index of a key map; bit 4 flags that any bit was set.
  function automatic logic [4:0] lowestSet(input logic [15:0] keyMap);
    logic [4:0] result;
    result = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      result = keyMap[i] ? {1'b1, 4'(i)} : result;
    end
    return result;
  endfunction

  logic [3:0]       rowsMeta_r;
  logic [3:0]       rowsSync_r;
  state_t           state_r;
  logic [CNT_W-1:0] counter_r;
  logic [1:0]       column_r;
  logic [15:0]      snapshot_r;
  logic [15:0]      previous_r;
  logic [15:0]      debounced_r;
  logic [15:0]      reported_r;
  logic [STB_W-1:0] stable_r;

  logic [STB_W-1:0] stableNext_s;
  logic [15:0]      mapNext_s;
  logic [15:0]      armed_s;
  logic [15:0]      grantBit_s;
  logic [4:0]       candidate_s;
  logic             candValid_s;
  logic [3:0]       candIdx_s;
  logic             grant_s;

  // Two-flop synchronizer on the externally pulled-up rows
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rowsMeta_r <= 4'hF;
      rowsSync_r <= 4'hF;
    end else begin
      rowsMeta_r <= Rows_i;
      rowsSync_r <= rowsMeta_r;
    end
  end

  // End-of-scan evaluation: stability count, accepted map and next key to report
  always_comb begin
    stableNext_s = {STB_W{1'b0}};
    mapNext_s    = debounced_r;
    if (snapshot_r == previous_r) begin
      if (stable_r == STABLE_MAX) begin
        stableNext_s = STABLE_MAX;
      end else begin
        stableNext_s = stable_r + STB_W'(1);
      end
    end else begin
      stableNext_s = {STB_W{1'b0}};
    end
    if (stableNext_s == STABLE_MAX) begin
      mapNext_s = snapshot_r;
    end else begin
      mapNext_s = debounced_r;
    end
    // A released key drops its reported bit, which re-arms it for the next press
    armed_s     = reported_r & mapNext_s;
    candidate_s = lowestSet(mapNext_s & ~armed_s);
    candValid_s = candidate_s[4];
    candIdx_s   = candidate_s[3:0];
    grantBit_s  = 16'h0001 << candIdx_s;
  end

  // Scan FSM: column dwell, row sampling, debounce and reported-map bookkeeping
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r      <= SETTLE;
      counter_r    <= {CNT_W{1'b0}};
      column_r     <= 2'd0;
      Columns_o    <= 4'b1110;
      snapshot_r   <= 16'h0000;
      previous_r   <= 16'h0000;
      debounced_r  <= 16'h0000;
      reported_r   <= 16'h0000;
      stable_r     <= {STB_W{1'b0}};
      KeyPressed_o <= 1'b0;
    end else begin
      case (state_r)
        SETTLE: begin
          if (counter_r == DELAY_C) begin
            counter_r <= {CNT_W{1'b0}};
            snapshot_r[{column_r, 2'b00} +: 4] <= ~rowsSync_r;
            if (column_r != 2'd3) begin
              column_r  <= column_r + 2'd1;
              Columns_o <= ~(4'b0001 << (column_r + 2'd1));
            end else begin
              state_r <= EVAL;
            end
          end else begin
            counter_r <= counter_r + CNT_W'(1);
          end
        end
        EVAL: begin
          stable_r     <= stableNext_s;
          previous_r   <= snapshot_r;
          debounced_r  <= mapNext_s;
          reported_r   <= grant_s ? (armed_s | grantBit_s) : armed_s;
          KeyPressed_o <= |mapNext_s;
          column_r     <= 2'd0;
          Columns_o    <= 4'b1110;
          state_r      <= SETTLE;
        end
        default: begin
          state_r   <= SETTLE;
          counter_r <= {CNT_W{1'b0}};
          column_r  <= 2'd0;
          Columns_o <= 4'b1110;
        end
      endcase
    end
  end

`ifdef KEYPAD_FIFO_EN
  logic [3:0] fifoMem_r [4];
  logic [1:0] fifoHead_r;
  logic [1:0] fifoTail_r;
  logic [2:0] fifoCount_r;
  logic       overflow_r;
  logic       fifoFull_s;
  logic       popReq_s;

  assign fifoFull_s = (fifoCount_r == 3'd4);
  assign grant_s    = (state_r == EVAL) && candValid_s && !fifoFull_s;
  assign popReq_s   = (fifoCount_r != 3'd0) && KeyAck_i;

  // Report FIFO: pushed from the scan evaluation, popped by the consumer ack
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) begin
        fifoMem_r[i] <= 4'd0;
      end
      fifoHead_r  <= 2'd0;
      fifoTail_r  <= 2'd0;
      fifoCount_r <= 3'd0;
      overflow_r  <= 1'b0;
    end else begin
      if (grant_s) begin
        fifoMem_r[fifoTail_r] <= candIdx_s;
        fifoTail_r            <= fifoTail_r + 2'd1;
      end
      if (popReq_s) begin
        fifoHead_r <= fifoHead_r + 2'd1;
      end
      fifoCount_r <= fifoCount_r + {2'b00, grant_s} - {2'b00, popReq_s};
      overflow_r  <= (state_r == EVAL) && candValid_s && fifoFull_s;
    end
  end

  assign KeyCode_o     = fifoMem_r[fifoHead_r];
  assign KeyValid_o    = (fifoCount_r != 3'd0);
  assign KeyOverflow_o = overflow_r;
`else
  logic       keyValid_r;
  logic [3:0] keyCode_r;

  // An ack arriving in the evaluation cycle frees the slot for the new code
  assign grant_s = (state_r == EVAL) && candValid_s && (!keyValid_r || KeyAck_i);

  // Single output slot holding one unacknowledged key code
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      keyValid_r <= 1'b0;
      keyCode_r  <= 4'd0;
    end else begin
      if (grant_s) begin
        keyCode_r  <= candIdx_s;
        keyValid_r <= 1'b1;
      end else if (KeyAck_i) begin
        keyValid_r <= 1'b0;
      end
    end
  end

  assign KeyCode_o  = keyCode_r;
  assign KeyValid_o = keyValid_r;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: scan-level vector table, reset/handshake corner sequences and
// randomized key maps checked every cycle against a history-based debounce/report model.
module tb_keypad_scanner;

  // Three-cycle dwell lets rows cross the 2-flop synchronizer before each column is sampled
  localparam int DWELL    = 3;
  localparam int SCAN_LEN = 4 * DWELL + 1;
  localparam int STABLE   = 3;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] Rows_i;
  logic [3:0] Columns_o;
  logic [3:0] KeyCode_o;
  logic       KeyValid_o;
  logic       KeyAck_i;
  logic       KeyPressed_o;

  logic [15:0] keys;

  always #5 Clock = ~Clock;

  keypad_scanner #(
    .CLOCK_HZ(1_000_000),
    .SCAN_US(DWELL),
    .STABLE_SCANS(STABLE)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Rows_i(Rows_i),
    .Columns_o(Columns_o),
    .KeyCode_o(KeyCode_o),
    .KeyValid_o(KeyValid_o),
    .KeyAck_i(KeyAck_i),
    .KeyPressed_o(KeyPressed_o)
  );

  // Physical matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    Rows_i = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!Columns_o[c] && keys[c*4+r]) Rows_i[r] = 1'b0;
      end
    end
  end

  typedef struct {
    logic [15:0] keys;
    int          ack;    // 0 none, 1 first cycle of scan, 2 random, 3 evaluation cycle
    logic        expValid;
    logic [3:0]  expCode;
    logic        expPressed;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int passes = 0;

  logic        mValid;
  logic [3:0]  mCode;
  logic        mPressed;
  logic [15:0] mMap;
  logic [15:0] mRep;
  logic [15:0] mSnap;
  logic [15:0] hist[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic addVec(input logic [15:0] k, input int a, input logic ev, input logic [3:0] ec,
                        input logic ep);
    vec_t v;
    v.keys = k; v.ack = a; v.expValid = ev; v.expCode = ec; v.expPressed = ep;
    vecs.push_back(v);
  endtask

  task automatic modelReset();
    mValid = 1'b0; mCode = 4'd0; mPressed = 1'b0; mMap = 16'h0000; mRep = 16'h0000;
    hist.delete();
    hist.push_back(16'h0000);
  endtask

  // A map is accepted once the last STABLE snapshots agree; one new report per scan
  task automatic modelStep(input int p, input logic ack);
    bit allSame;
    int cand;
    if (p == SCAN_LEN - 1) begin
      hist.push_back(mSnap);
      if (hist.size() > STABLE) void'(hist.pop_front());
      allSame = (hist.size() == STABLE);
      foreach (hist[i]) if (hist[i] != mSnap) allSame = 1'b0;
      if (allSame) mMap = mSnap;
      mRep &= mMap;
      cand = -1;
      for (int i = 15; i >= 0; i--) if (mMap[i] && !mRep[i]) cand = i;
      if (cand >= 0 && (!mValid || ack)) begin
        mCode = 4'(cand); mValid = 1'b1; mRep[cand] = 1'b1;
      end else if (ack) begin
        mValid = 1'b0;
      end
      mPressed = |mMap;
    end else if (ack) begin
      mValid = 1'b0;
    end
  endtask

  function automatic logic [3:0] expCols(input int q);
    int col;
    logic [3:0] one;
    one = 4'b0001;
    col = q / DWELL;
    if (col > 3) col = 3;
    return ~(one << col);
  endfunction

  task automatic checkResetValues(input string tag);
    check({tag, "_columns"}, 16'(Columns_o), 16'h000E);
    check({tag, "_valid"}, 16'(KeyValid_o), 16'h0000);
    check({tag, "_code"}, 16'(KeyCode_o), 16'h0000);
    check({tag, "_pressed"}, 16'(KeyPressed_o), 16'h0000);
  endtask

  // Asynchronous reset taken mid-cycle; released just after a rising edge
  task automatic doReset();
    KeyAck_i = 1'b0;
    Reset = 1'b0;
    #2;
    checkResetValues("reset_async");
    repeat (2) @(posedge Clock);
    #1;
    checkResetValues("reset_held");
    modelReset();
    Reset = 1'b1;
  endtask

  task automatic runScan(input logic [15:0] k, input int ackMode, input int cycles);
    for (int p = 0; p < cycles; p++) begin
      logic a;
      if (p == 0) begin
        keys = k;
        mSnap = k;
      end
      case (ackMode)
        1: a = (p == 0);
        2: a = ($urandom_range(0, 3) == 0);
        3: a = (p == SCAN_LEN - 1);
        default: a = 1'b0;
      endcase
      KeyAck_i = a;
      @(posedge Clock);
      modelStep(p, a);
      #1;
      check("columns", 16'(Columns_o), 16'(expCols((p + 1) % SCAN_LEN)));
      check("valid", 16'(KeyValid_o), 16'(mValid));
      check("code", 16'(KeyCode_o), 16'(mCode));
      check("pressed", 16'(KeyPressed_o), 16'(mPressed));
    end
    KeyAck_i = 1'b0;
  endtask

  initial begin
    logic [15:0] rk;
    Reset = 1'b1;
    KeyAck_i = 1'b0;
    keys = 16'h0000;

    // Expected outputs after each scan's evaluation (STABLE=3)
    repeat (2) addVec(16'h0000, 0, 1'b0, 4'd0, 1'b0);
    repeat (2) addVec(16'h0200, 0, 1'b0, 4'd0, 1'b0);
    repeat (2) addVec(16'h0200, 0, 1'b1, 4'd9, 1'b1);
    addVec(16'h0200, 1, 1'b0, 4'd9, 1'b1);
    addVec(16'h0200, 0, 1'b0, 4'd9, 1'b1);
    repeat (2) addVec(16'h0000, 0, 1'b0, 4'd9, 1'b1);
    addVec(16'h0000, 0, 1'b0, 4'd9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      addVec(16'h0040, 0, 1'b0, 4'd9, 1'b0);
      addVec(16'h0000, 0, 1'b0, 4'd9, 1'b0);
    end
    repeat (2) addVec(16'h0040, 0, 1'b0, 4'd9, 1'b0);
    addVec(16'h0040, 0, 1'b1, 4'd6, 1'b1);
    addVec(16'h0040, 1, 1'b0, 4'd6, 1'b1);
    repeat (2) addVec(16'h1008, 0, 1'b0, 4'd6, 1'b1);
    addVec(16'h1008, 0, 1'b1, 4'd3, 1'b1);
    addVec(16'h1008, 1, 1'b1, 4'd12, 1'b1);
    addVec(16'h1008, 1, 1'b0, 4'd12, 1'b1);
    repeat (2) addVec(16'h0003, 3, 1'b0, 4'd12, 1'b1);
    addVec(16'h0003, 3, 1'b1, 4'd0, 1'b1);
    addVec(16'h0003, 3, 1'b1, 4'd1, 1'b1);
    addVec(16'h0003, 3, 1'b0, 4'd1, 1'b1);
    repeat (2) addVec(16'h0000, 0, 1'b0, 4'd1, 1'b1);
    addVec(16'h0000, 0, 1'b0, 4'd1, 1'b0);
    repeat (2) addVec(16'h0020, 0, 1'b0, 4'd1, 1'b0);
    addVec(16'h0020, 0, 1'b1, 4'd5, 1'b1);
    addVec(16'h0020, 1, 1'b0, 4'd5, 1'b1);
    repeat (2) addVec(16'h0000, 0, 1'b0, 4'd5, 1'b1);
    addVec(16'h0000, 0, 1'b0, 4'd5, 1'b0);
    repeat (2) addVec(16'h0020, 0, 1'b0, 4'd5, 1'b0);
    addVec(16'h0020, 0, 1'b1, 4'd5, 1'b1);

    #1;
    doReset();

    foreach (vecs[i]) begin
      runScan(vecs[i].keys, vecs[i].ack, SCAN_LEN);
      check($sformatf("tbl%0d_valid", i), 16'(KeyValid_o), 16'(vecs[i].expValid));
      check($sformatf("tbl%0d_code", i), 16'(KeyCode_o), 16'(vecs[i].expCode));
      check($sformatf("tbl%0d_pressed", i), 16'(KeyPressed_o), 16'(vecs[i].expPressed));
    end

    // Reset in the middle of a scan with key 5 still pending: the code is lost
    runScan(16'h0020, 0, 5);
    doReset();
    repeat (3) runScan(16'h0000, 0, SCAN_LEN);
    check("after_reset_valid", 16'(KeyValid_o), 16'h0000);

    // Randomized key maps held for random spans with random acks
    rk = 16'h0000;
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 3) == 0) rk = 16'($urandom & $urandom & $urandom);
      runScan(rk, 2, SCAN_LEN);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
